phase_decoder: RTL
==================

# phase_decoder

Receiving end of the 4-phase sequencer bus. Samples a one-hot phase word each enabled clock, decodes it to a 2-bit phase index, checks that consecutive phases step by exactly one (mod 4), and reports lock, per-sample errors and a saturating error count. It sits downstream of the 2-flip-flop sequencer and feeds supervisory logic that must know whether the sequencer is running cleanly.

## Interface
- `LOCK_CNT`, default 4: consecutive correct steps required to enter LOCKED; legal range 1..15.
- `ERR_W`, default 8: width of `ERR_CNT`.

- `CLK`  in  1  rising-edge clock.
- `CLR`  in  1  asynchronous, active-low reset; `CLR`=0 clears all state immediately.
- `E`  in  1  sample enable; `PH` is evaluated only on edges where `E`=1.
- `PH`  in  4  one-hot phase word; bit n set means phase n.
- `IDX`  out  2  decoded index of the last legal phase accepted.
- `VALID`  out  1  `IDX` is meaningful (state ACQUIRE or LOCKED).
- `LOCK`  out  1  state is LOCKED.
- `ERR`  out  1  one-cycle pulse per erroneous sample.
- `ERR_CNT`  out  `ERR_W`  count of `ERR` pulses, saturating.
- `DIR`  out  1  step direction: 0 ascending, 1 descending.

## Operation
- Legal sample: `PH` has exactly one bit set. Illegal: zero bits or more than one bit set.
- Expected next phase: `IDX`+1 mod 4, or `IDX`-1 mod 4 when `DIR`=1.
- `good` is an internal 4-bit counter of consecutive correct steps.
- IDLE (reset state):
  - Legal sample: load `IDX`, set `good`=0, go to ACQUIRE.
  - Illegal sample: `ERR`, stay in IDLE.
- ACQUIRE:
  - Expected phase: `good`+1 and update `IDX`. When `good`+1 = `LOCK_CNT`, go to LOCKED.
  - Legal but wrong phase: `ERR`, reload `IDX` from `PH`, set `good`=0, stay in ACQUIRE.
  - Illegal sample: `ERR`, go to IDLE.
- LOCKED:
  - Expected phase: update `IDX`, stay in LOCKED.
  - Any other sample: `ERR`, go to FAULT. `IDX` holds its last good value.
- FAULT:
  - Legal sample: load `IDX`, set `good`=0, go to ACQUIRE.
  - Illegal sample: `ERR`, stay in FAULT.
- `E`=0: state, `IDX`, `good` and `DIR` all hold. `PH` is ignored and no `ERR` is raised.
- A repeated phase (same as `IDX`) counts as a wrong step.
- `ERR_CNT` increments on every `ERR` and sticks at 2^`ERR_W`-1. It clears only on reset.

## Timing
- All outputs are registered. The response to the sample taken at edge k is visible after edge k.
- Decode latency is 1 cycle. `LOCK` rises on the same edge that accepts the `LOCK_CNT`-th correct step.
- `ERR` is high for exactly one cycle per offending edge. Back-to-back bad samples give back-to-back pulses.
- Reset values: `IDX`=0, `VALID`=0, `LOCK`=0, `ERR`=0, `ERR_CNT`=0, `DIR`=0, state IDLE.
- `CLR` asserted mid-sequence forces reset values asynchronously, without waiting for `CLK`.
- After `CLR` deasserts, the first enabled edge is treated as an IDLE sample.
- `IDX` wrap-around: 3→0 ascending and 0→3 descending are correct steps.

## Configuration
- `PHASE_DECODER_REVERSE_EN` defined:
  - In ACQUIRE with `good`=0, a step of -1 sets `DIR`=1 and counts as correct.
  - `DIR` is latched until the next IDLE or FAULT exit.
  - Steps opposite to the latched `DIR` are wrong steps.
- `PHASE_DECODER_REVERSE_EN` not defined:
  - `DIR` is tied to 0.
  - Descending steps are wrong steps.

## Test plan
- `CLR`=0 pulse mid-run, no clock edge during it → all outputs return to reset values immediately. Next `PH`=0010 with `E`=1 → `IDX`=1, `VALID`=1.
- `E`=1, `PH` sequence 0001,0010,0100,1000,0001 with `LOCK_CNT`=4 → `IDX` steps 0,1,2,3,0. `LOCK` rises after the 5th edge. `ERR` never asserts.
- While LOCKED at `IDX`=2, apply `PH`=0001 → `ERR` pulses one cycle, `LOCK`=0, `ERR_CNT`=1, `IDX` holds at 2.
- Apply `PH`=0110, then 0000, with `E`=1 → two consecutive `ERR` pulses, state IDLE, `VALID`=0.
- `ERR_W`=2 with 5 illegal samples → `ERR_CNT` reads 1,2,3,3,3.
- `E`=0 for 3 cycles with `PH`=0000 → no `ERR`, `IDX`/`LOCK` unchanged. With the macro defined, sequence 0100,0010,0001,1000 → `DIR`=1, no `ERR`.

Source files
------------

// File: rtl/phase_decoder.sv
// phase_decoder: receiver for the one-hot 4-phase sequencer bus.
// Optional descending-sequence acceptance via PHASE_DECODER_REVERSE_EN.
module phase_decoder #(
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             E,
   input  logic [3:0]       PH,
   output logic [1:0]       IDX,
   output logic             VALID,
   output logic             LOCK,
   output logic             ERR,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic             DIR
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACQ   = 2'd1;
   localparam logic [1:0] S_LOCK  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
   localparam logic [ERR_W-1:0] CNT_MAX = '1;

   logic [1:0]       state_q;
   logic [1:0]       state_n;
   logic [1:0]       idx_q;
   logic [1:0]       idx_n;
   logic [3:0]       good_q;
   logic [3:0]       good_n;
   logic             valid_q;
   logic             lock_q;
   logic             err_q;
   logic             err_n;
   logic [ERR_W-1:0] cnt_q;

   logic             ph_one;
   logic [1:0]       ph_idx;
   logic [1:0]       idx_up;
   logic [1:0]       idx_dn;
   logic             step_up;
   logic             step_dn;
   logic             fwd_ok;
   logic             rev_take;
   logic [3:0]       good_inc;
   logic             hit_lock;

`ifdef PHASE_DECODER_REVERSE_EN
   logic dir_q;
   logic dir_n;

   // First correct step of an acquisition may go downward and fixes DIR.
   assign rev_take = (good_q == 4'd0) && !dir_q && step_dn;
`else
   logic dir_q;

   assign dir_q    = 1'b0;
   assign rev_take = 1'b0;
`endif

   // Exactly one bit set: nonzero and clearing the lowest bit leaves zero.
   assign ph_one = (PH != 4'd0) && ((PH & (PH - 4'd1)) == 4'd0);

   // Index of the highest set bit; only consumed when ph_one is true.
   always_comb begin
      ph_idx = 2'd0;
      case (1'b1)
         PH[3]:   ph_idx = 2'd3;
         PH[2]:   ph_idx = 2'd2;
         PH[1]:   ph_idx = 2'd1;
         default: ph_idx = 2'd0;
      endcase
   end

   assign idx_up   = idx_q + 2'd1;
   assign idx_dn   = idx_q - 2'd1;
   assign step_up  = (ph_idx == idx_up);
   assign step_dn  = (ph_idx == idx_dn);
   assign fwd_ok   = ph_one && (dir_q ? step_dn : step_up);
   assign good_inc = good_q + 4'd1;
   assign hit_lock = (good_inc == LOCK_N);

   // Next-state, index, step counter and error decision for one sample.
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      good_n  = good_q;
      err_n   = 1'b0;
`ifdef PHASE_DECODER_REVERSE_EN
      dir_n   = dir_q;
`endif
      if (E) begin
         unique case (state_q)
            S_IDLE, S_FAULT: begin
               if (ph_one) begin
                  idx_n   = ph_idx;
                  good_n  = 4'd0;
                  state_n = S_ACQ;
`ifdef PHASE_DECODER_REVERSE_EN
                  dir_n   = 1'b0;
`endif
               end else begin
                  err_n = 1'b1;
               end
            end
            S_ACQ: begin
               if (!ph_one) begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end else if (fwd_ok || rev_take) begin
                  idx_n  = ph_idx;
                  good_n = good_inc;
                  if (hit_lock) begin
                     state_n = S_LOCK;
                  end
`ifdef PHASE_DECODER_REVERSE_EN
                  if (rev_take) begin
                     dir_n = 1'b1;
                  end
`endif
               end else begin
                  err_n  = 1'b1;
                  idx_n  = ph_idx;
                  good_n = 4'd0;
               end
            end
            S_LOCK: begin
               if (fwd_ok) begin
                  idx_n = ph_idx;
               end else begin
                  err_n   = 1'b1;
                  state_n = S_FAULT;
               end
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // Core state registers; outputs are registered from the next values.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         good_q  <= 4'd0;
         valid_q <= 1'b0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         good_q  <= good_n;
         valid_q <= (state_n == S_ACQ) || (state_n == S_LOCK);
         lock_q  <= (state_n == S_LOCK);
         err_q   <= err_n;
      end
   end

   // Saturating error counter, cleared only by reset.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         cnt_q <= '0;
      end else if (err_n && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef PHASE_DECODER_REVERSE_EN
   // Direction latch, reloaded to ascending on every acquisition start.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         dir_q <= 1'b0;
      end else begin
         dir_q <= dir_n;
      end
   end
`endif

   assign IDX     = idx_q;
   assign VALID   = valid_q;
   assign LOCK    = lock_q;
   assign ERR     = err_q;
   assign ERR_CNT = cnt_q;
   assign DIR     = dir_q;

endmodule
